// File: rtl/jt12_snd_pkg.sv
// jt12_snd_pkg: shared sound widths and I2S frame geometry
package jt12_snd_pkg;
   localparam int SW = 16;
   localparam int SLOTS = 32;
   // one slot is two sclk half-periods of 2^divw clocks each
   function automatic int frame_bits(input int divw);
      return divw + 1 + $clog2(SLOTS);
   endfunction
   function automatic int frame_len(input int divw);
      return 1 << frame_bits(divw);
   endfunction
endpackage

// File: rtl/jt12_snd_avg.sv
// jt12_snd_avg: per-frame sample accumulator with floor average over 2^N samples
module jt12_snd_avg
   import jt12_snd_pkg::*;
#(
   parameter int N = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 last,
   input  logic signed [SW-1:0] din,
   output logic signed [SW-1:0] hold
);
   logic signed [SW+N-1:0] acc, sum;
   assign sum = acc + (SW+N)'(din);
   // taking bits [N +: SW] of the sum is the floor shift; the result always fits SW bits
   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         hold <= '0;
      end else if (!en) acc <= '0;
      else if (last) begin
         acc  <= '0;
         hold <= sum[N +: SW];
      end else acc <= sum;
   end
endmodule

// File: rtl/jt12_i2s_tx.sv
// jt12_i2s_tx: averages stereo samples over one frame and sends them as I2S
module jt12_i2s_tx
   import jt12_snd_pkg::*;
#(
   parameter int DIVW = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic signed [SW-1:0] snd_left,
   input  logic signed [SW-1:0] snd_right,
   output logic                 sclk,
   output logic                 lrclk,
   output logic                 sdata,
   output logic                 sample_stb
);
   localparam int N = frame_bits(DIVW);
   localparam logic [N-1:0] SLOT1 = N'(1 << (DIVW + 1));
   logic [N-1:0] cnt, cnt_n;
   logic last;
   logic signed [SW-1:0] hold_l, hold_r;
   logic [2*SW-1:0] shreg;
   assign cnt_n = cnt + N'(1);
   assign last = en && (&cnt);
   assign sdata = shreg[2*SW-1];
   // outputs follow the value cnt takes at this edge, so sclk falls together with the data change
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt        <= '0;
         shreg      <= '0;
         sclk       <= 1'b0;
         lrclk      <= 1'b0;
         sample_stb <= 1'b0;
      end else begin
         cnt        <= cnt_n;
         sclk       <= cnt_n[DIVW];
         lrclk      <= cnt_n[N-1];
         sample_stb <= last;
         if (cnt_n == SLOT1) shreg <= {hold_l, hold_r};
         else if (cnt_n[DIVW:0] == '0) shreg <= {shreg[2*SW-2:0], 1'b0};
      end
   end
   jt12_snd_avg #(.N(N)) u_avg_l (
      .clk(clk), .rst(rst), .en(en), .last(last), .din(snd_left), .hold(hold_l)
   );
   jt12_snd_avg #(.N(N)) u_avg_r (
      .clk(clk), .rst(rst), .en(en), .last(last), .din(snd_right), .hold(hold_r)
   );
endmodule

// File: tb/tb_jt12_i2s_tx.sv
// tb_jt12_i2s_tx: directed frame-level checks of the I2S transmitter with DIVW=4
module tb_jt12_i2s_tx;
   logic clk = 1'b0;
   logic rst, en, alt;
   logic signed [15:0] l, r;
   logic sclk, lrclk, sdata, sample_stb;
   int bc = 0;
   int pass_cnt = 0;
   int total = 0;
   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      logic        alt;
      logic [15:0] el;
      logic [15:0] er;
   } vec_t;
   vec_t vt[6];
   jt12_i2s_tx #(.DIVW(4)) dut (
      .clk(clk), .rst(rst), .en(en), .snd_left(l), .snd_right(r),
      .sclk(sclk), .lrclk(lrclk), .sdata(sdata), .sample_stb(sample_stb)
   );
   always #5 clk = ~clk;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask
   // bc is the bench's own model of the frame counter
   task automatic tick();
      int nb;
      nb = (rst || !en) ? 0 : (bc + 1) % 1024;
      @(posedge clk);
      #1;
      bc = nb;
      if (alt) begin
         l = -l;
         r = -r;
      end
   endtask
   task automatic goto_cnt(input int c);
      int n;
      n = 0;
      while (bc != c && n < 1100) begin
         tick();
         n++;
      end
      if (bc != c) check("goto_cnt timeout", 32'(bc), 32'(c));
   endtask
   task automatic check_zero(input string nm);
      check(nm, {28'd0, sclk, lrclk, sdata, sample_stb}, 32'd0);
   endtask
   // captures slots 1..31 of the frame starting now plus slot 0 of the following frame
   task automatic capture(output logic [31:0] w, output int stb_at, output int terr);
      logic prev;
      w = '0;
      stb_at = -1;
      terr = 0;
      prev = sdata;
      for (int i = 1; i <= 1056; i++) begin
         tick();
         if (sclk !== bc[4] || lrclk !== bc[9]) terr++;
         if (sdata !== prev && bc[4:0] != 0) terr++;
         prev = sdata;
         if (sample_stb) begin
            if (stb_at < 0) stb_at = i;
            else terr++;
         end
         if (bc[4:0] == 16) begin
            if (bc[9:5] != 0) w[32 - bc[9:5]] = sdata;
            else if (i > 512) w[0] = sdata;
         end
      end
   endtask
   initial begin
      logic [31:0] w;
      int sa, te;
      vt[0] = '{16'h1234, 16'hFEDC, 1'b0, 16'h1234, 16'hFEDC};
      vt[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFF};
      vt[2] = '{16'h7FFF, 16'h8000, 1'b0, 16'h7FFF, 16'h8000};
      vt[3] = '{16'h8000, 16'h7FFF, 1'b0, 16'h8000, 16'h7FFF};
      vt[4] = '{16'h0064, 16'hFF9C, 1'b1, 16'h0000, 16'h0000};
      vt[5] = '{16'h0003, 16'hA5C3, 1'b0, 16'h0003, 16'hA5C3};
      rst = 1'b1;
      en = 1'b0;
      alt = 1'b0;
      l = '0;
      r = '0;
      tick();
      tick();
      check_zero("reset outputs");
      rst = 1'b0;
      tick();
      check_zero("idle outputs");
      en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         l = vt[k].l;
         r = vt[k].r;
         alt = vt[k].alt;
         goto_cnt(0);
         repeat (1024) tick();
         capture(w, sa, te);
         check($sformatf("vec%0d left", k), {16'd0, w[31:16]}, {16'd0, vt[k].el});
         check($sformatf("vec%0d right", k), {16'd0, w[15:0]}, {16'd0, vt[k].er});
         check($sformatf("vec%0d stb cycle", k), 32'(sa), 32'd1024);
         check($sformatf("vec%0d timing errors", k), 32'(te), 32'd0);
      end
      alt = 1'b0;
      l = 16'h1234;
      r = 16'hFEDC;
      goto_cnt(0);
      repeat (1024) tick();
      goto_cnt(300);
      en = 1'b0;
      tick();
      check_zero("en drop outputs");
      check("en drop cnt", 32'(bc), 32'd0);
      l = 16'h5555;
      r = 16'h5555;
      repeat (5) tick();
      check_zero("en low outputs");
      en = 1'b1;
      capture(w, sa, te);
      check("reenable held data", w, 32'h1234FEDC);
      check("reenable stb cycle", 32'(sa), 32'd1024);
      check("reenable timing errors", 32'(te), 32'd0);
      goto_cnt(20 * 32 + 5);
      check("slot20 lrclk", {31'd0, lrclk}, 32'd1);
      rst = 1'b1;
      tick();
      check_zero("mid-frame reset outputs");
      rst = 1'b0;
      capture(w, sa, te);
      check("post-reset data", w, 32'd0);
      check("post-reset stb cycle", 32'(sa), 32'd1024);
      check("post-reset timing errors", 32'(te), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
